// File: rtl/disc_reader_pkg.sv
// Shared widths, codes and byte-packing helper for the floppy flux/index timestamper.
package disc_reader_pkg;

  localparam int unsigned CNT_WIDTH  = 7;
  localparam int unsigned DATA_WIDTH = CNT_WIDTH + 1;
  localparam int unsigned IDX_BIT    = CNT_WIDTH;

  typedef logic [CNT_WIDTH-1:0]  count_t;
  typedef logic [DATA_WIDTH-1:0] sample_t;

  localparam count_t CARRY_CODE = '1;

  // Per-cycle action chosen by the datapath, in priority order.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_STOP,
    ACT_PENDING,
    ACT_EVENT,
    ACT_CARRY,
    ACT_COLLIDE,
    ACT_COUNT
  } action_t;

  function automatic sample_t pack_sample(input logic idx, input count_t cnt);
    sample_t s;
    s                  = '0;
    s[CNT_WIDTH-1:0]   = cnt;
    s[IDX_BIT]         = idx;
    return s;
  endfunction

endpackage

// File: rtl/disc_reader_edge_det.sv
// Rising-edge detector whose history register advances only on clock-enabled cycles.
module disc_reader_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic clken,
  input  logic din,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b0;
    end else if (clken) begin
      prev <= din;
    end
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/disc_reader.sv
// Flux/index interval timestamper: one {idx, interval} byte per event, carry bytes on overflow.
module disc_reader
  import disc_reader_pkg::*;
(
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  CLKEN,
  input  logic                  RUN,
  input  logic                  FD_RDDATA_IN,
  input  logic                  FD_INDEX_IN,
  output logic [DATA_WIDTH-1:0] DATA,
  output logic                  WRITE
);

  logic               rd_edge;
  logic               idx_edge;
  logic               event_hit;
  count_t             counter;
  logic               pending;
  logic               pend_idx;
  logic [CNT_WIDTH:0] count_inc;
  action_t            act;

  disc_reader_edge_det u_rd_edge (
    .clk   (CLOCK),
    .rst   (RESET),
    .clken (CLKEN),
    .din   (FD_RDDATA_IN),
    .rise  (rd_edge)
  );

  disc_reader_edge_det u_idx_edge (
    .clk   (CLOCK),
    .rst   (RESET),
    .clken (CLKEN),
    .din   (FD_INDEX_IN),
    .rise  (idx_edge)
  );

  assign event_hit = rd_edge | idx_edge;
  assign count_inc = {1'b0, counter} + 1'b1;

  // Counter never exceeds CARRY_CODE-1, so count_inc tops out at CARRY_CODE.
  always_comb begin
    act = ACT_HOLD;
    if (!CLKEN) begin
      act = ACT_HOLD;
    end else if (!RUN) begin
      act = ACT_STOP;
    end else if (pending) begin
      act = ACT_PENDING;
    end else if (count_inc == {1'b0, CARRY_CODE}) begin
      act = event_hit ? ACT_COLLIDE : ACT_CARRY;
    end else if (event_hit) begin
      act = ACT_EVENT;
    end else begin
      act = ACT_COUNT;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      DATA     <= '0;
      WRITE    <= 1'b0;
      counter  <= '0;
      pending  <= 1'b0;
      pend_idx <= 1'b0;
    end else begin
      WRITE <= 1'b0;
      unique case (act)
        ACT_HOLD: ;
        ACT_STOP: begin
          counter <= '0;
          pending <= 1'b0;
        end
        ACT_PENDING: begin
          DATA    <= pack_sample(pend_idx | idx_edge, '0);
          WRITE   <= 1'b1;
          pending <= 1'b0;
          counter <= count_inc[CNT_WIDTH-1:0];
        end
        ACT_EVENT: begin
          DATA    <= pack_sample(idx_edge, count_inc[CNT_WIDTH-1:0]);
          WRITE   <= 1'b1;
          counter <= '0;
        end
        ACT_CARRY: begin
          DATA    <= pack_sample(1'b0, CARRY_CODE);
          WRITE   <= 1'b1;
          counter <= '0;
        end
        ACT_COLLIDE: begin
          DATA     <= pack_sample(1'b0, CARRY_CODE);
          WRITE    <= 1'b1;
          counter  <= '0;
          pending  <= 1'b1;
          pend_idx <= idx_edge;
        end
        ACT_COUNT: begin
          counter <= count_inc[CNT_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_disc_reader.sv
// Scoreboard bench for disc_reader: behavioural model predicts bytes, monitor pops and compares.
module tb_disc_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clken = 1'b1;
  logic       run = 1'b0;
  logic       rd = 1'b0;
  logic       ix = 1'b0;
  logic [7:0] data;
  logic       write;

  disc_reader dut (
    .CLOCK        (clk),
    .RESET        (rst),
    .CLKEN        (clken),
    .RUN          (run),
    .FD_RDDATA_IN (rd),
    .FD_INDEX_IN  (ix),
    .DATA         (data),
    .WRITE        (write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned n_writes = 0;
  logic [7:0]  last_data = '0;
  logic [7:0]  prev_data = '0;

  // Reference model state
  int unsigned m_cnt = 0;
  bit          m_rdp = 0;
  bit          m_ixp = 0;
  bit          m_pend = 0;
  bit          m_pidx = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  task automatic model_push(input logic [7:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic model_step();
    bit re, ie;
    if (rst) begin
      m_cnt = 0; m_rdp = 0; m_ixp = 0; m_pend = 0; m_pidx = 0;
    end else if (clken) begin
      re = rd && !m_rdp;
      ie = ix && !m_ixp;
      m_rdp = rd;
      m_ixp = ix;
      if (!run) begin
        m_cnt = 0;
        m_pend = 0;
      end else if (m_pend) begin
        model_push({m_pidx | ie, 7'd0});
        m_pend = 0;
        m_cnt++;
      end else if ((re || ie) && m_cnt + 1 < 127) begin
        model_push({ie, 7'(m_cnt + 1)});
        m_cnt = 0;
      end else if (m_cnt + 1 == 127) begin
        model_push(8'h7F);
        m_cnt = 0;
        if (re || ie) begin
          m_pend = 1;
          m_pidx = ie;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (write) begin
      n_writes++;
      prev_data = last_data;
      last_data = data;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", {24'd0, data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("data", {24'd0, data}, {24'd0, e.data});
        check_eq("write_cycle", cyc, e.cyc);
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      check_eq("missed_write", {31'd0, write}, 32'd1);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    cyc++;
    #1;
    monitor();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  int unsigned w0;

  initial begin
    // Reset
    rst = 1'b1; run = 1'b0; clken = 1'b1; rd = 1'b0; ix = 1'b0;
    idle(10);
    check_eq("reset_data", {24'd0, data}, 32'd0);
    check_eq("reset_write", {31'd0, write}, 32'd0);
    rst = 1'b0;

    // 1-clk data pulse right as RUN rises -> 0x01
    w0 = n_writes;
    run = 1'b1; rd = 1'b1; tick();
    rd = 1'b0; idle(5);
    check_eq("s1_writes", n_writes - w0, 32'd1);
    check_eq("s1_data", {24'd0, last_data}, 32'h01);

    // long pulse counts once -> 0x06
    w0 = n_writes;
    rd = 1'b1; idle(20);
    check_eq("s2_writes", n_writes - w0, 32'd1);
    check_eq("s2_data", {24'd0, last_data}, 32'h06);

    // 300 idle clks from a cleared counter -> two carries, then remainder
    rd = 1'b0; run = 1'b0; tick();
    run = 1'b1;
    w0 = n_writes;
    idle(300);
    check_eq("s3_carries", n_writes - w0, 32'd2);
    check_eq("s3_carry_data", {24'd0, last_data}, 32'h7F);
    idle(10);
    rd = 1'b1; tick();
    check_eq("s3_remainder", {24'd0, last_data}, 32'd57);
    check_eq("s3_sum", 32'd254 + {25'd0, last_data[6:0]}, 32'd311);

    // simultaneous data+index at count 4, then index alone
    rd = 1'b0; idle(3);
    rd = 1'b1; ix = 1'b1; tick();
    check_eq("s4_both", {24'd0, last_data}, 32'h84);
    rd = 1'b0; ix = 1'b0; idle(2);
    ix = 1'b1; tick();
    check_eq("s4_index", {24'd0, last_data}, 32'h83);

    // edge at counter=126 -> carry + zero byte, then next interval
    ix = 1'b0; idle(126);
    rd = 1'b1; tick();
    check_eq("s5_collide", {24'd0, last_data}, 32'h7F);
    rd = 1'b0; tick();
    check_eq("s5_pending", {24'd0, last_data}, 32'h00);
    check_eq("s5_pending_prev", {24'd0, prev_data}, 32'h7F);
    idle(4);
    rd = 1'b1; tick();
    check_eq("s5_after", {24'd0, last_data}, 32'h06);

    // index edge landing on the pending cycle merges into the zero byte
    rd = 1'b0; idle(126);
    rd = 1'b1; tick();
    rd = 1'b0; ix = 1'b1; tick();
    check_eq("s5_idx_merge", {24'd0, last_data}, 32'h80);
    ix = 1'b0;

    // CLKEN every 2nd clock: only enabled cycles count
    for (int unsigned i = 0; i < 10; i++) begin
      clken = 1'b0; tick();
      clken = 1'b1; tick();
    end
    clken = 1'b0; tick();
    clken = 1'b1; rd = 1'b1; tick();
    check_eq("s6_clken", {24'd0, last_data}, 32'd12);

    // RUN=0 blocks writes; restart with data already high
    rd = 1'b0; run = 1'b0;
    w0 = n_writes;
    tick();
    rd = 1'b1; tick();
    rd = 1'b0; idle(8);
    check_eq("s7_no_writes", n_writes - w0, 32'd0);
    run = 1'b1; rd = 1'b1; tick();
    check_eq("s7_restart", {24'd0, last_data}, 32'h01);

    // randomised traffic, dense then sparse
    for (int unsigned i = 0; i < 2000; i++) begin
      clken = ($urandom_range(3) != 0);
      run   = ($urandom_range(199) != 0);
      rd    = ($urandom_range(30) == 0) ? 1'b1 : (rd & 1'($urandom_range(1)));
      ix    = ($urandom_range(120) == 0);
      tick();
    end
    for (int unsigned i = 0; i < 2000; i++) begin
      clken = ($urandom_range(4) != 0);
      run   = 1'b1;
      rd    = ($urandom_range(200) == 0);
      ix    = ($urandom_range(400) == 0);
      tick();
    end

    rd = 1'b0; ix = 1'b0; clken = 1'b1; run = 1'b0;
    idle(4);
    check_eq("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
